// File: rtl/psum_collector_pkg.sv
// Shared types for the systolic-array output collector.
// FSM encodings and array-wide width defaults.
package psum_collector_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } st_t;

endpackage

// File: rtl/psum_collector_if.sv
// Skewed partial-sum input and deskewed row output stream.
// The collector is the slave; the array/host side is the master.
interface psum_collector_if #(
  parameter int N = 4,
  parameter int W = 16
) ();

  logic           in_valid;
  logic [N*W-1:0] c_in;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic           out_last;

  modport slave (
    input  in_valid, c_in, out_ready,
    output out_valid, out_data, out_last
  );

  modport master (
    output in_valid, c_in, out_ready,
    input  out_valid, out_data, out_last
  );

endinterface

// File: rtl/psum_fifo.sv
// Row FIFO with concurrent push/pop; push while full only
// succeeds if a pop frees the slot in the same cycle.
module psum_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         one
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [W-1:0]  hold;
  logic          wr_en, rd_en;

  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign one   = cnt == (AW+1)'(1);
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // hold keeps the last popped entry visible once empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      hold   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      cnt <= cnt + (AW+1)'(wr_en)
                 - (AW+1)'(rd_en);
    end
  end

  assign dout = empty ? hold : mem[rd_ptr];

endmodule

// File: rtl/psum_collector.sv
// Deskews bottom-row partial sums into rows, frames ROWS rows.
// PSUM_COLLECT_RELU_EN clamps negative columns to zero.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int N         = 4,
  parameter int ACC_WIDTH = 16,
  parameter int ROWS      = 4,
  parameter int DEPTH     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  psum_collector_if.slave bus,
  output logic busy,
  output logic done,
  output logic overflow
);

  localparam int DW = N * ACC_WIDTH;
  localparam int RW = $clog2(ROWS + 1);

  st_t           state, state_nxt;
  logic [RW-1:0] iss_cnt, row_cnt;
  logic [N-1:1]  vd;
  logic [DW-1:0] pr [1:N-1];
  logic [DW-1:0] row_raw, row_in;
  logic [DW:0]   fifo_dout;
  logic          accept, push, pop, drop;
  logic          push_last, last_drop;
  logic          full, empty, one;
  logic          done_nxt, begin_frame;

  assign begin_frame = (state == ST_IDLE) & start;
  assign accept = bus.in_valid
                & (state == ST_COLLECT)
                & (iss_cnt < RW'(ROWS));
  assign push      = vd[N-1];
  assign push_last = row_cnt == RW'(ROWS - 1);
  assign pop       = bus.out_valid & bus.out_ready;
  assign drop      = push & full & ~pop;

  // pr[j] carries columns 0..j-1 of the row whose valid is vd[j]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vd <= '0;
      for (int j = 1; j < N; j++) pr[j] <= '0;
    end else begin
      vd[1] <= accept;
      for (int j = 2; j < N; j++) vd[j] <= vd[j-1];
      pr[1] <= DW'(bus.c_in[ACC_WIDTH-1:0]);
      for (int j = 1; j < N - 1; j++) begin
        pr[j+1] <= pr[j];
        pr[j+1][j*ACC_WIDTH +: ACC_WIDTH]
          <= bus.c_in[j*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  always_comb begin
    row_raw = pr[N-1];
    row_raw[(N-1)*ACC_WIDTH +: ACC_WIDTH]
      = bus.c_in[(N-1)*ACC_WIDTH +: ACC_WIDTH];
  end

`ifdef PSUM_COLLECT_RELU_EN
  always_comb begin
    row_in = row_raw;
    for (int j = 0; j < N; j++)
      if (row_raw[j*ACC_WIDTH + ACC_WIDTH - 1])
        row_in[j*ACC_WIDTH +: ACC_WIDTH] = '0;
  end
`else
  assign row_in = row_raw;
`endif

  psum_fifo #(
    .W    (DW + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  ({push_last, row_in}),
    .pop  (pop),
    .dout (fifo_dout),
    .full (full),
    .empty(empty),
    .one  (one)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_data  = fifo_dout[DW-1:0];
  assign bus.out_last  = ~empty & fifo_dout[DW];
  assign busy          = state != ST_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      iss_cnt   <= '0;
      row_cnt   <= '0;
      overflow  <= 1'b0;
      last_drop <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (begin_frame) begin
        iss_cnt   <= '0;
        row_cnt   <= '0;
        overflow  <= 1'b0;
        last_drop <= 1'b0;
      end else begin
        if (accept) iss_cnt <= iss_cnt + 1'b1;
        if (push)   row_cnt <= row_cnt + 1'b1;
        if (drop)   overflow <= 1'b1;
        if (drop & push_last) last_drop <= 1'b1;
      end
    end
  end

  // a dropped last row ends the frame once the FIFO runs dry
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE:
        if (start) state_nxt = ST_COLLECT;
      ST_COLLECT:
        if (push & push_last) state_nxt = ST_DRAIN;
      ST_DRAIN:
        if ((pop & bus.out_last) |
            (last_drop & (empty | (pop & one)))) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench: three collectors with ROWS = 1, 4 and 6.
// Expected rows are hand-written constants.
module tb_psum_collector;

  logic clk = 1'b0;
  logic rst_n;
  logic st1, st4, st6;
  logic busy1, busy4, busy6;
  logic done1, done4, done6;
  logic ovf1, ovf4, ovf6;
  int   vecs = 0;
  int   errs = 0;
  logic [63:0] exp_row [6];

  psum_collector_if #(.N(4), .W(16)) b1 ();
  psum_collector_if #(.N(4), .W(16)) b4 ();
  psum_collector_if #(.N(4), .W(16)) b6 ();

  psum_collector #(
    .N(4), .ACC_WIDTH(16), .ROWS(1), .DEPTH(4)
  ) u_r1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .bus(b1),
    .busy(busy1), .done(done1), .overflow(ovf1)
  );

  psum_collector #(
    .N(4), .ACC_WIDTH(16), .ROWS(4), .DEPTH(4)
  ) u_r4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .bus(b4),
    .busy(busy4), .done(done4), .overflow(ovf4)
  );

  psum_collector #(
    .N(4), .ACC_WIDTH(16), .ROWS(6), .DEPTH(4)
  ) u_r6 (
    .clk(clk), .rst_n(rst_n), .start(st6), .bus(b6),
    .busy(busy6), .done(done6), .overflow(ovf6)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // column j of row r = (r+1)*0x100 + j, skewed by j cycles
  function automatic logic [63:0] skew(int k, int n);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      int r;
      r = k - j;
      if (r >= 0 && r < n) v[j*16 +: 16] = 16'((r + 1) * 256 + j);
    end
    return v;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    vecs++;
    if (b4.out_valid !== 1'b0 || b4.out_last !== 1'b0) begin
      errs++;
      $display("FAIL reset_out got v=%b l=%b want 0 0",
               b4.out_valid, b4.out_last);
    end
    vecs++;
    if (b4.out_data !== 64'h0) begin
      errs++;
      $display("FAIL reset_data got %h want 0", b4.out_data);
    end
    vecs++;
    if ({busy1, busy4, busy6, done4, ovf4} !== 5'b0) begin
      errs++;
      $display("FAIL reset_flags got %b want 00000",
               {busy1, busy4, busy6, done4, ovf4});
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_row;
    logic ev;
    b1.out_ready = 1'b1;
    st1 = 1'b1;
    tick;
    st1 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      b1.in_valid = (k == 0);
      b1.c_in = '0;
      if (k < 4) b1.c_in[k*16 +: 16] = 16'(k + 1);
      ev = (k == 4);
      vecs++;
      if (b1.out_valid !== ev) begin
        errs++;
        $display("FAIL single_valid k=%0d got %b want %b",
                 k, b1.out_valid, ev);
      end
      if (ev) begin
        vecs++;
        if (b1.out_data !== 64'h0004_0003_0002_0001 ||
            b1.out_last !== 1'b1) begin
          errs++;
          $display("FAIL single_row got %h/%b want %h/1",
                   b1.out_data, b1.out_last,
                   64'h0004_0003_0002_0001);
        end
      end
      vecs++;
      if (done1 !== (k == 5)) begin
        errs++;
        $display("FAIL single_done k=%0d got %b want %b",
                 k, done1, (k == 5));
      end
      if (k == 0 || k == 5) begin
        vecs++;
        if (busy1 !== (k == 0)) begin
          errs++;
          $display("FAIL single_busy k=%0d got %b want %b",
                   k, busy1, (k == 0));
        end
      end
      tick;
    end
    b1.in_valid = 1'b0;
  endtask

  task automatic test_idle_ignore;
    b1.in_valid = 1'b1;
    b1.c_in = '1;
    tick;
    b1.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      vecs++;
      if (b1.out_valid !== 1'b0 || busy1 !== 1'b0) begin
        errs++;
        $display("FAIL idle_ignore k=%0d got v=%b busy=%b want 0 0",
                 k, b1.out_valid, busy1);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    logic ev;
    b4.out_ready = 1'b1;
    st4 = 1'b1;
    tick;
    st4 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      b4.in_valid = (k < 5);
      b4.c_in = skew(k, 5);
      ev = (k >= 4 && k <= 7);
      vecs++;
      if (b4.out_valid !== ev) begin
        errs++;
        $display("FAIL b2b_valid k=%0d got %b want %b",
                 k, b4.out_valid, ev);
      end
      if (ev) begin
        vecs++;
        if (b4.out_data !== exp_row[k-4] ||
            b4.out_last !== (k == 7)) begin
          errs++;
          $display("FAIL b2b_row k=%0d got %h/%b want %h/%b",
                   k, b4.out_data, b4.out_last,
                   exp_row[k-4], (k == 7));
        end
      end
      vecs++;
      if (done4 !== (k == 8)) begin
        errs++;
        $display("FAIL b2b_done k=%0d got %b want %b",
                 k, done4, (k == 8));
      end
      if (k == 7 || k == 8) begin
        vecs++;
        if (busy4 !== (k == 7)) begin
          errs++;
          $display("FAIL b2b_busy k=%0d got %b want %b",
                   k, busy4, (k == 7));
        end
      end
      tick;
    end
    b4.in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    logic ev;
    b6.out_ready = 1'b0;
    st6 = 1'b1;
    tick;
    st6 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      b6.out_ready = (k >= 10);
      b6.in_valid = (k < 6);
      b6.c_in = skew(k, 6);
      ev = (k >= 4 && k <= 13);
      vecs++;
      if (b6.out_valid !== ev) begin
        errs++;
        $display("FAIL bp_valid k=%0d got %b want %b",
                 k, b6.out_valid, ev);
      end
      if (ev) begin
        vecs++;
        if (b6.out_data !== exp_row[k < 10 ? 0 : k - 10] ||
            b6.out_last !== 1'b0) begin
          errs++;
          $display("FAIL bp_row k=%0d got %h/%b want %h/0",
                   k, b6.out_data, b6.out_last,
                   exp_row[k < 10 ? 0 : k - 10]);
        end
      end
      if (k == 7 || k == 8 || k == 14) begin
        vecs++;
        if (ovf6 !== (k != 7)) begin
          errs++;
          $display("FAIL bp_overflow k=%0d got %b want %b",
                   k, ovf6, (k != 7));
        end
      end
      vecs++;
      if (done6 !== (k == 14)) begin
        errs++;
        $display("FAIL bp_done k=%0d got %b want %b",
                 k, done6, (k == 14));
      end
      if (k == 9 || k == 14) begin
        vecs++;
        if (busy6 !== (k == 9)) begin
          errs++;
          $display("FAIL bp_busy k=%0d got %b want %b",
                   k, busy6, (k == 9));
        end
      end
      tick;
    end
    b6.in_valid = 1'b0;
  endtask

  task automatic test_full_pop_push;
    logic ev;
    b6.out_ready = 1'b0;
    st6 = 1'b1;
    tick;
    st6 = 1'b0;
    for (int k = 0; k < 15; k++) begin
      b6.out_ready = (k >= 7);
      b6.in_valid = (k < 6);
      b6.c_in = skew(k, 6);
      ev = (k >= 4 && k <= 12);
      vecs++;
      if (b6.out_valid !== ev) begin
        errs++;
        $display("FAIL fpp_valid k=%0d got %b want %b",
                 k, b6.out_valid, ev);
      end
      if (ev) begin
        vecs++;
        if (b6.out_data !== exp_row[k < 7 ? 0 : k - 7] ||
            b6.out_last !== (k == 12)) begin
          errs++;
          $display("FAIL fpp_row k=%0d got %h/%b want %h/%b",
                   k, b6.out_data, b6.out_last,
                   exp_row[k < 7 ? 0 : k - 7], (k == 12));
        end
      end
      vecs++;
      if (ovf6 !== 1'b0) begin
        errs++;
        $display("FAIL fpp_overflow k=%0d got %b want 0", k, ovf6);
      end
      vecs++;
      if (done6 !== (k == 13)) begin
        errs++;
        $display("FAIL fpp_done k=%0d got %b want %b",
                 k, done6, (k == 13));
      end
      tick;
    end
    b6.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    b4.out_ready = 1'b0;
    st4 = 1'b1;
    tick;
    st4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      b4.in_valid = (k < 4);
      b4.c_in = skew(k, 4);
      tick;
    end
    vecs++;
    if (b4.out_valid !== 1'b1 || b4.out_data !== exp_row[0]) begin
      errs++;
      $display("FAIL mid_pre got %b/%h want 1/%h",
               b4.out_valid, b4.out_data, exp_row[0]);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (b4.out_valid !== 1'b0 || b4.out_data !== 64'h0 ||
        b4.out_last !== 1'b0) begin
      errs++;
      $display("FAIL mid_rst_out got %b/%h/%b want 0/0/0",
               b4.out_valid, b4.out_data, b4.out_last);
    end
    tick;
    vecs++;
    if ({busy4, done4, ovf4, b4.out_valid} !== 4'b0) begin
      errs++;
      $display("FAIL mid_rst_flags got %b want 0000",
               {busy4, done4, ovf4, b4.out_valid});
    end
    b4.in_valid = 1'b0;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_relu;
    logic [15:0] cv [4];
    logic [63:0] ed;
    cv[0] = 16'h0001;
    cv[1] = 16'h8000;
    cv[2] = 16'hFFF0;
    cv[3] = 16'h7FFF;
`ifdef PSUM_COLLECT_RELU_EN
    ed = 64'h7FFF_0000_0000_0001;
`else
    ed = 64'h7FFF_FFF0_8000_0001;
`endif
    b1.out_ready = 1'b1;
    st1 = 1'b1;
    tick;
    st1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b1.in_valid = (k == 0);
      b1.c_in = '0;
      if (k < 4) b1.c_in[k*16 +: 16] = cv[k];
      if (k == 4) begin
        vecs++;
        if (b1.out_valid !== 1'b1 || b1.out_data !== ed) begin
          errs++;
          $display("FAIL relu got %b/%h want 1/%h",
                   b1.out_valid, b1.out_data, ed);
        end
      end
      tick;
    end
    b1.in_valid = 1'b0;
  endtask

  initial begin
    exp_row[0] = 64'h0103_0102_0101_0100;
    exp_row[1] = 64'h0203_0202_0201_0200;
    exp_row[2] = 64'h0303_0302_0301_0300;
    exp_row[3] = 64'h0403_0402_0401_0400;
    exp_row[4] = 64'h0503_0502_0501_0500;
    exp_row[5] = 64'h0603_0602_0601_0600;
    {st1, st4, st6} = '0;
    b1.in_valid = 1'b0; b1.c_in = '0; b1.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.c_in = '0; b4.out_ready = 1'b0;
    b6.in_valid = 1'b0; b6.c_in = '0; b6.out_ready = 1'b0;
    test_reset;
    test_single_row;
    test_idle_ignore;
    test_back_to_back;
    test_backpressure;
    test_full_pop_push;
    test_reset_mid;
    test_back_to_back;
    test_relu;
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
